// File: rtl/pingpong_pkg.sv
// Shared types and defaults for the ping/pong sweep scheduler.
package pingpong_pkg;

  localparam int unsigned NSEL_DEF     = 16;
  localparam int unsigned PIPE_LAT_DEF = 4;
  localparam int unsigned SelW         = 4;
  localparam int unsigned CntW         = 5;
  localparam int unsigned DataW        = 8;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/pingpong_sweep_sched_if.sv
// Requester, pang-window and mux-pipeline signals of the ping/pong sweep scheduler.
interface pingpong_sweep_sched_if;

  logic       ping_req;
  logic       pong_req;
  logic       pang_en;
  logic [3:0] pang_start;
  logic [3:0] pang_end;
  logic       stall;
  logic       takeblk;
  logic [7:0] subblk;

  logic [3:0] sel;
  logic       needpang;
  logic       myturnpingpong;
  logic [3:0] needpangstartinc;
  logic [3:0] needpangendinc;
  logic       gnt_ping;
  logic       gnt_pong;
  logic       busy;
  logic       blk_valid;
  logic [7:0] blk_data;
  logic       done;
  logic       done_owner;
  logic [4:0] taken_cnt;

  modport master (
    output ping_req, pong_req, pang_en, pang_start, pang_end, stall, takeblk, subblk,
    input  sel, needpang, myturnpingpong, needpangstartinc, needpangendinc, gnt_ping,
           gnt_pong, busy, blk_valid, blk_data, done, done_owner, taken_cnt
  );

  modport slave (
    input  ping_req, pong_req, pang_en, pang_start, pang_end, stall, takeblk, subblk,
    output sel, needpang, myturnpingpong, needpangstartinc, needpangendinc, gnt_ping,
           gnt_pong, busy, blk_valid, blk_data, done, done_owner, taken_cnt
  );

endinterface

// File: rtl/valid_delay_line.sv
// Slot-valid shift register that lines a sweep slot up with the mux pipeline return.
module valid_delay_line #(
  parameter int unsigned Depth = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic slot_valid,
  output logic tail_valid,
  output logic empty_next
);

  logic [Depth-1:0] vld_q, vld_d;

  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = slot_valid;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign tail_valid = vld_q[Depth-1];
  assign empty_next = (vld_d == '0);

endmodule

// File: rtl/pingpong_sweep_sched.sv
// Grants ping or pong a full NSEL-slot mux sweep, realigns slot valids with the
// pipelined mux return and reports how many blocks the owner received.
module pingpong_sweep_sched
  import pingpong_pkg::*;
#(
  parameter int unsigned NSEL     = NSEL_DEF,
  parameter int unsigned PIPE_LAT = PIPE_LAT_DEF
) (
  input logic                   clk,
  input logic                   reset,
  pingpong_sweep_sched_if.slave bus
);

  localparam logic [SelW-1:0] SelLast = SelW'(NSEL - 1);

  state_e          state_q;
  logic [SelW-1:0] sel_q;
  logic            needpang_q;
  logic [3:0]      pang_start_q, pang_end_q;
  logic            gnt_ping_q, gnt_pong_q;
  logic            done_q, done_owner_q;
  logic [CntW-1:0] taken_cnt_q;
  logic            last_pong_q;

  logic grant, grant_pong, sweep_adv, tail_valid, drain_empty, blk_valid;

  // On contention the side not served last wins.
  assign grant      = bus.ping_req | bus.pong_req;
  assign grant_pong = bus.pong_req & (~bus.ping_req | ~last_pong_q);
  assign sweep_adv  = (state_q == StSweep) & ~bus.stall;
  assign blk_valid  = tail_valid & bus.takeblk;

  valid_delay_line #(
    .Depth(PIPE_LAT)
  ) u_valid_delay_line (
    .clk       (clk),
    .reset     (reset),
    .slot_valid(sweep_adv),
    .tail_valid(tail_valid),
    .empty_next(drain_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      sel_q        <= '0;
      needpang_q   <= 1'b0;
      pang_start_q <= '0;
      pang_end_q   <= '0;
      gnt_ping_q   <= 1'b0;
      gnt_pong_q   <= 1'b0;
      done_q       <= 1'b0;
      done_owner_q <= 1'b0;
      taken_cnt_q  <= '0;
      last_pong_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      if (blk_valid) taken_cnt_q <= taken_cnt_q + CntW'(1);
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            state_q      <= StSweep;
            sel_q        <= '0;
            needpang_q   <= bus.pang_en;
            pang_start_q <= bus.pang_start;
            pang_end_q   <= bus.pang_end;
            gnt_ping_q   <= ~grant_pong;
            gnt_pong_q   <= grant_pong;
            last_pong_q  <= grant_pong;
            taken_cnt_q  <= '0;
          end
        end
        StSweep: begin
          if (!bus.stall) begin
            if (sel_q == SelLast) begin
              sel_q   <= '0;
              state_q <= StDrain;
            end else begin
              sel_q <= sel_q + SelW'(1);
            end
          end
        end
        StDrain: begin
          if (drain_empty) begin
            state_q      <= StDone;
            done_q       <= 1'b1;
            done_owner_q <= gnt_pong_q;
          end
        end
        StDone: begin
          state_q    <= StIdle;
          gnt_ping_q <= 1'b0;
          gnt_pong_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.sel              = sel_q;
  assign bus.needpang         = needpang_q;
  assign bus.needpangstartinc = pang_start_q;
  assign bus.needpangendinc   = pang_end_q;
  assign bus.myturnpingpong   = (state_q == StSweep);
  assign bus.busy             = (state_q != StIdle);
  assign bus.gnt_ping         = gnt_ping_q;
  assign bus.gnt_pong         = gnt_pong_q;
  assign bus.done             = done_q;
  assign bus.done_owner       = done_owner_q;
  assign bus.taken_cnt        = taken_cnt_q;
  assign bus.blk_valid        = blk_valid;
  assign bus.blk_data         = bus.subblk;

endmodule

// File: tb/tb_pingpong_sweep_sched.sv
// Randomised bench for pingpong_sweep_sched with a behavioural mux pipeline and
// a slot-list reference model of what each grant should deliver.
module tb_pingpong_sweep_sched;
  import pingpong_pkg::*;

  localparam int LAT = int'(PIPE_LAT_DEF);
  localparam int NS  = int'(NSEL_DEF);

  typedef struct {
    int         wait_cyc;
    int         sweep_cyc;
    int         drain_cyc;
    int         stall_cyc;
    int         done_gap;
    bit         timeout;
    bit         sel_ok;
    logic       gp;
    logic       gq;
    logic       owner;
    logic       np;
    logic [3:0] ns;
    logic [3:0] ne;
    logic [4:0] cnt;
  } obs_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  pingpong_sweep_sched_if bus ();

  pingpong_sweep_sched #(
    .NSEL    (NSEL_DEF),
    .PIPE_LAT(PIPE_LAT_DEF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] data_tbl [NS];
  bit         take_mask[NS];
  logic [3:0] pipe_sel [LAT];
  bit         pipe_turn[LAT];
  logic [7:0] got      [$];

  initial forever #5 clk = ~clk;

  // Mux pipeline: the select seen in one cycle comes back PIPE_LAT cycles later.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      bus.takeblk = pipe_turn[LAT-1] && take_mask[pipe_sel[LAT-1]];
      bus.subblk  = pipe_turn[LAT-1] ? data_tbl[pipe_sel[LAT-1]] : 8'($urandom);
      for (int i = LAT - 1; i > 0; i--) begin
        pipe_sel[i]  = pipe_sel[i-1];
        pipe_turn[i] = pipe_turn[i-1];
      end
      pipe_sel[0]  = bus.sel;
      pipe_turn[0] = bus.myturnpingpong;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required to have finished");
    $fatal(1);
  end

  function automatic logic [24:0] out_bits();
    return {bus.sel, bus.needpang, bus.needpangstartinc, bus.needpangendinc,
            bus.myturnpingpong, bus.gnt_ping, bus.gnt_pong, bus.busy, bus.done,
            bus.done_owner, bus.taken_cnt, bus.blk_valid};
  endfunction

  function automatic int popcnt();
    int c = 0;
    for (int s = 0; s < NS; s++) c += int'(take_mask[s]);
    return c;
  endfunction

  // Reference: the owner receives the data of every taken slot, in slot order.
  function automatic int blk_errors();
    logic [7:0] exp_q[$];
    int         e;
    for (int s = 0; s < NS; s++) if (take_mask[s]) exp_q.push_back(data_tbl[s]);
    e = (exp_q.size() != got.size()) ? 1 : 0;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) if (got[i] !== exp_q[i]) e++;
    return e;
  endfunction

  task automatic fill_tables(input int mode);
    for (int s = 0; s < NS; s++) begin
      data_tbl[s] = 8'($urandom);
      case (mode)
        0:       take_mask[s] = 1'b1;
        1:       take_mask[s] = (s > 5);
        default: take_mask[s] = bit'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic apply_reset();
    reset        = 1'b0;
    bus.ping_req = 1'b0;
    bus.pong_req = 1'b0;
    bus.stall    = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic observe(input int stall_at, input int stall_len, input bit rnd_stall,
                         input int drop_at, output obs_t o);
    int acc = 0, det = 0, n = 0, last_cyc = 0;
    bit seen = 1'b0, fin = 1'b0;
    o = '{default: 0};
    o.sel_ok = 1'b1;
    got.delete();
    while (!fin) begin
      @(negedge clk);
      n++;
      if (bus.blk_valid === 1'b1) got.push_back(bus.blk_data);
      if (bus.myturnpingpong === 1'b1) begin
        if (!seen) begin
          seen = 1'b1;
          o.wait_cyc = n;
          o.gp = bus.gnt_ping;
          o.gq = bus.gnt_pong;
          // Window inputs move after the grant; the latched copy must not.
          bus.pang_en    = 1'($urandom);
          bus.pang_start = 4'($urandom);
          bus.pang_end   = 4'($urandom);
        end
        o.sweep_cyc++;
        if (bus.sel !== 4'(acc)) o.sel_ok = 1'b0;
        if (bus.sel == 4'(stall_at) && det < stall_len) begin
          bus.stall = 1'b1;
          det++;
        end else begin
          bus.stall = rnd_stall && ($urandom_range(0, 3) == 0);
        end
        if (bus.stall) o.stall_cyc++;
        else begin
          acc++;
          if (acc == NS) last_cyc = n;
          if (acc == drop_at) begin
            bus.ping_req = 1'b0;
            bus.pong_req = 1'b0;
          end
        end
      end else begin
        bus.stall = rnd_stall && ($urandom_range(0, 3) == 0);
        if (seen && bus.done === 1'b1) begin
          o.done_gap = n - last_cyc;
          o.owner    = bus.done_owner;
          o.cnt      = bus.taken_cnt;
          o.np       = bus.needpang;
          o.ns       = bus.needpangstartinc;
          o.ne       = bus.needpangendinc;
          fin        = 1'b1;
        end else if (seen && bus.busy === 1'b1) begin
          o.drain_cyc++;
        end
      end
      if (n >= 400 && !fin) begin
        o.timeout = 1'b1;
        fin       = 1'b1;
      end
    end
    bus.stall = 1'b0;
  endtask

  task automatic test_reset();
    reset          = 1'b0;
    bus.ping_req   = 1'($urandom);
    bus.pong_req   = 1'($urandom);
    bus.pang_en    = 1'b1;
    bus.pang_start = 4'($urandom);
    bus.pang_end   = 4'($urandom);
    repeat (2) @(negedge clk);
    vectors++;
    if (out_bits() !== 25'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0", out_bits());
    end
    bus.ping_req = 1'b0;
    bus.pong_req = 1'b0;
    reset        = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0 || bus.sel !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b sel=%0d want busy=0 sel=0", bus.busy, bus.sel);
    end
  endtask

  task automatic test_single();
    obs_t o;
    fill_tables(0);
    bus.pang_en  = 1'b0;
    bus.ping_req = 1'b1;
    observe(-1, 0, 1'b0, -1, o);
    bus.ping_req = 1'b0;
    vectors++;
    if (o.timeout) begin miscompares++; $display("FAIL single_timeout: no done, want done"); end
    vectors++;
    if (o.gp !== 1'b1 || o.gq !== 1'b0) begin
      miscompares++;
      $display("FAIL single_gnt: got ping=%b pong=%b want 1/0", o.gp, o.gq);
    end
    vectors++;
    if (!o.sel_ok) begin miscompares++; $display("FAIL single_sel: sel not 0..15 in order"); end
    vectors++;
    if (o.sweep_cyc != NS) begin
      miscompares++;
      $display("FAIL single_turn_cycles: got %0d want %0d", o.sweep_cyc, NS);
    end
    vectors++;
    if (o.drain_cyc != LAT || o.done_gap != LAT + 1) begin
      miscompares++;
      $display("FAIL single_done_timing: drain %0d gap %0d want %0d/%0d", o.drain_cyc,
               o.done_gap, LAT, LAT + 1);
    end
    vectors++;
    if (o.cnt !== 5'd16 || o.owner !== 1'b0) begin
      miscompares++;
      $display("FAIL single_report: cnt %0d owner %b want 16/0", o.cnt, o.owner);
    end
    vectors++;
    if (blk_errors() != 0) begin
      miscompares++;
      $display("FAIL single_blocks: %0d errors in %0d blocks, want 0", blk_errors(), got.size());
    end
    @(negedge clk);
    vectors++;
    if (bus.gnt_ping !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL single_exit: gnt %b busy %b done %b want 0/0/0", bus.gnt_ping, bus.busy,
               bus.done);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    bit   exp_owner[3] = '{1'b0, 1'b1, 1'b0};
    apply_reset();
    fill_tables(0);
    bus.ping_req = 1'b1;
    bus.pong_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      observe(-1, 0, 1'b0, -1, o);
      vectors++;
      if (o.timeout || o.owner !== exp_owner[k] || o.gq !== exp_owner[k] ||
          o.gp !== !exp_owner[k]) begin
        miscompares++;
        $display("FAIL b2b_owner[%0d]: owner %b gnt %b%b want %b", k, o.owner, o.gp, o.gq,
                 exp_owner[k]);
      end
      if (k > 0) begin
        vectors++;
        if (o.wait_cyc != 2) begin
          miscompares++;
          $display("FAIL b2b_gap[%0d]: grant %0d cycles after done, want 2", k, o.wait_cyc);
        end
      end
    end
    bus.ping_req = 1'b0;
    bus.pong_req = 1'b0;
  endtask

  task automatic test_pang();
    obs_t       o;
    logic [3:0] st[2] = '{4'd4, 4'd12};
    logic [3:0] en[2] = '{4'd9, 4'd3};
    for (int k = 0; k < 2; k++) begin
      fill_tables(0);
      bus.pang_en    = 1'b1;
      bus.pang_start = st[k];
      bus.pang_end   = en[k];
      bus.pong_req   = 1'b1;
      observe(-1, 0, 1'b0, -1, o);
      bus.pong_req = 1'b0;
      vectors++;
      if (o.np !== 1'b1 || o.ns !== st[k] || o.ne !== en[k]) begin
        miscompares++;
        $display("FAIL pang_window[%0d]: got %b %0d..%0d want 1 %0d..%0d", k, o.np, o.ns,
                 o.ne, st[k], en[k]);
      end
      vectors++;
      if (o.timeout || o.cnt !== 5'd16 || o.owner !== 1'b1 || blk_errors() != 0) begin
        miscompares++;
        $display("FAIL pang_taken[%0d]: cnt %0d owner %b want 16/1", k, o.cnt, o.owner);
      end
    end
  endtask

  task automatic test_stall();
    obs_t o;
    fill_tables(0);
    bus.ping_req = 1'b1;
    observe(7, 3, 1'b0, -1, o);
    bus.ping_req = 1'b0;
    vectors++;
    if (o.timeout || !o.sel_ok || o.stall_cyc != 3) begin
      miscompares++;
      $display("FAIL stall_sel: sel_ok %b stalls %0d want 1/3", o.sel_ok, o.stall_cyc);
    end
    vectors++;
    if (o.sweep_cyc != NS + 3) begin
      miscompares++;
      $display("FAIL stall_sweep_len: got %0d want %0d", o.sweep_cyc, NS + 3);
    end
    vectors++;
    if (o.cnt !== 5'd16 || blk_errors() != 0) begin
      miscompares++;
      $display("FAIL stall_taken: cnt %0d blocks %0d want 16", o.cnt, got.size());
    end
  endtask

  task automatic test_reset_mid();
    bit hit = 1'b0;
    fill_tables(0);
    bus.ping_req = 1'b1;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (bus.myturnpingpong === 1'b1 && bus.sel === 4'd10) hit = 1'b1;
    end
    vectors++;
    if (!hit) begin miscompares++; $display("FAIL reset_mid_reach: sel never 10, want 10"); end
    reset        = 1'b0;
    bus.ping_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_bits() !== 25'd0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got %h want 0", out_bits());
    end
    reset = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.blk_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid_flush[%0d]: blk_valid %b want 0", i, bus.blk_valid);
      end
    end
  endtask

  task automatic test_partial_take();
    obs_t o;
    fill_tables(1);
    bus.ping_req = 1'b1;
    observe(-1, 0, 1'b0, -1, o);
    bus.ping_req = 1'b0;
    vectors++;
    if (o.timeout || o.cnt !== 5'd10 || got.size() != 10) begin
      miscompares++;
      $display("FAIL partial_cnt: cnt %0d blocks %0d want 10/10", o.cnt, got.size());
    end
    vectors++;
    if (blk_errors() != 0) begin
      miscompares++;
      $display("FAIL partial_blocks: %0d errors, want 0", blk_errors());
    end
  endtask

  task automatic test_random();
    obs_t       o;
    bit         last_pong = 1'b1;
    bit         exp_owner;
    logic [1:0] r;
    logic       p_en;
    logic [3:0] p_st, p_en_d;
    apply_reset();
    for (int it = 0; it < 8; it++) begin
      fill_tables(2);
      r      = 2'($urandom_range(1, 3));
      p_en   = 1'($urandom);
      p_st   = 4'($urandom);
      p_en_d = 4'($urandom);
      bus.ping_req   = r[0];
      bus.pong_req   = r[1];
      bus.pang_en    = p_en;
      bus.pang_start = p_st;
      bus.pang_end   = p_en_d;
      exp_owner      = (r[0] && r[1]) ? !last_pong : r[1];
      last_pong      = exp_owner;
      observe(-1, 0, 1'b1, ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 15)) : -1, o);
      vectors++;
      if (o.timeout || o.owner !== exp_owner || o.gq !== exp_owner || o.gp !== !exp_owner) begin
        miscompares++;
        $display("FAIL rand_owner[%0d]: owner %b gnt %b%b want %b", it, o.owner, o.gp, o.gq,
                 exp_owner);
      end
      vectors++;
      if (!o.sel_ok || o.sweep_cyc != NS + o.stall_cyc || o.drain_cyc != LAT) begin
        miscompares++;
        $display("FAIL rand_timing[%0d]: sel_ok %b sweep %0d stalls %0d drain %0d", it,
                 o.sel_ok, o.sweep_cyc, o.stall_cyc, o.drain_cyc);
      end
      vectors++;
      if (o.cnt !== 5'(popcnt()) || blk_errors() != 0) begin
        miscompares++;
        $display("FAIL rand_taken[%0d]: cnt %0d want %0d, block errors %0d", it, o.cnt,
                 popcnt(), blk_errors());
      end
      vectors++;
      if (o.np !== p_en || o.ns !== p_st || o.ne !== p_en_d) begin
        miscompares++;
        $display("FAIL rand_window[%0d]: got %b %0d..%0d want %b %0d..%0d", it, o.np, o.ns,
                 o.ne, p_en, p_st, p_en_d);
      end
      if (it > 0) begin
        vectors++;
        if (o.wait_cyc != 2) begin
          miscompares++;
          $display("FAIL rand_gap[%0d]: grant %0d cycles after done, want 2", it, o.wait_cyc);
        end
      end
    end
    bus.ping_req = 1'b0;
    bus.pong_req = 1'b0;
  endtask

  initial begin
    bus.ping_req   = 1'b0;
    bus.pong_req   = 1'b0;
    bus.pang_en    = 1'b0;
    bus.pang_start = 4'd0;
    bus.pang_end   = 4'd0;
    bus.stall      = 1'b0;
    bus.takeblk    = 1'b0;
    bus.subblk     = 8'd0;
    for (int i = 0; i < LAT; i++) begin
      pipe_sel[i]  = 4'd0;
      pipe_turn[i] = 1'b0;
    end
    fill_tables(0);
    test_reset();
    test_single();
    test_back_to_back();
    test_pang();
    test_stall();
    test_reset_mid();
    test_partial_take();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
